hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline hazard controller. Drives the enable/flush controls of the IF, IF/ID and ID/EX stage registers, plus a flush for EX/MEM. Detects load-use hazards, taken-branch redirects and multi-cycle EX operations (FSM plus latency counter). It also produces the EX-stage operand forwarding selects and keeps stall/flush performance counters.

Parameters:
MC_LAT, 4, total EX residency in cycles of a multi-cycle op (legal range 2..16)
WB_LD, 2'b01, wb_sel encoding that marks a load (data comes from memory)
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  core clock
rst_n  in  1  reset
rs1_addr_D  in  5  rs1 index of the instruction in ID
rs2_addr_D  in  5  rs2 index of the instruction in ID
rs1_addr_E  in  5  rs1 index of the instruction in EX
rs2_addr_E  in  5  rs2 index of the instruction in EX
rd_addr_E  in  5  destination of the instruction in EX
reg_wr_en_E  in  1  EX instruction writes the register file
wb_sel_E  in  2  writeback select of the EX instruction
rd_addr_M  in  5  destination in MEM
reg_wr_en_M  in  1  MEM instruction writes the register file
rd_addr_W  in  5  destination in WB
reg_wr_en_W  in  1  WB instruction writes the register file
br_taken_E  in  1  branch/jump resolved taken in EX
mc_req_E  in  1  EX instruction is a multi-cycle op
perf_clr  in  1  synchronous clear of the performance counters
enable_F  out  1  PC register enable
enable_D  out  1  IF/ID enable
flush_D  out  1  IF/ID flush
enable_E  out  1  ID/EX enable
flush_E  out  1  ID/EX flush
flush_M  out  1  EX/MEM flush (inserts a bubble)
mc_done  out  1  final cycle of a multi-cycle op; EX captures the result
fwd_a_sel  out  2  EX operand A source: 00 register file, 01 MEM, 10 WB
fwd_b_sel  out  2  EX operand B source, same encoding
stall_cnt  out  CNT_W  cycles with enable_D=0
flush_cnt  out  CNT_W  taken-branch flush events

Behaviour:
- One clock, clk. rst_n is asynchronous, active-low.
- Reset: state=RUN, mc_cnt=0, stall_cnt=0, flush_cnt=0, mc_done=0. Combinational outputs follow the RUN rules.
- Reset asserted mid multi-cycle op aborts it; after release the block is in RUN.
- Default outputs (no hazard): all enables 1, all flushes 0.
- load_use = reg_wr_en_E & (wb_sel_E==WB_LD) & (rd_addr_E!=0) & (rd_addr_E==rs1_addr_D | rd_addr_E==rs2_addr_D).
- FSM states are RUN and BUSY. mc_cnt is 4 bits.
- RUN, priority order:
  1. br_taken_E: flush_D=1, flush_E=1, enables stay 1. load_use is ignored.
  2. mc_req_E: enable_F=enable_D=enable_E=0, flush_M=1; mc_cnt<=MC_LAT-2; next state BUSY.
  3. load_use: enable_F=enable_D=0, flush_E=1 (one bubble into EX), enable_E=1.
- br_taken_E and mc_req_E are mutually exclusive by decode. If both are high, the branch wins and no MC op starts.
- BUSY with mc_cnt!=0: enable_F=enable_D=enable_E=0, flush_M=1, mc_cnt decrements. br_taken_E, mc_req_E and load_use are ignored.
- BUSY with mc_cnt==0 (release cycle): enables 1, flush_M=0, mc_done=1, next state RUN. mc_req_E still high this cycle is not a new request.
- A multi-cycle op occupies EX for exactly MC_LAT cycles and stalls the front end for MC_LAT-1 cycles. Back-to-back MC ops restart from RUN on the following cycle.
- Forwarding (combinational, per operand, shown for A):
  - MEM hit = reg_wr_en_M & rd_addr_M!=0 & rd_addr_M==rs1_addr_E. MEM hit gives 01.
  - Otherwise the same test against WB gives 10.
  - Otherwise 00. Register x0 is never forwarded; MEM has priority over WB.
- Counters:
  - stall_cnt += 1 each cycle enable_D==0.
  - flush_cnt += 1 each cycle br_taken_E is honoured.
  - Both wrap modulo 2^CNT_W.
  - perf_clr zeroes both on the next edge; perf_clr wins over an increment in the same cycle.

Test Plan:
- Load-use: EX has lw x5 (wb_sel_E=01, rd=5), ID has add rs1=5 -> one cycle of enable_F=enable_D=0, flush_E=1; next cycle all enables 1; stall_cnt=1.
- Branch vs load-use: br_taken_E=1 together with a load_use condition -> flush_D=flush_E=1, enable_D=1; flush_cnt=1, stall_cnt=0.
- Multi-cycle, MC_LAT=4: mc_req_E held high -> enable_E=0 and flush_M=1 for 3 cycles, mc_done=1 on cycle 4, RUN on cycle 5; stall_cnt=3. Repeat with MC_LAT=2 -> 1 stall cycle.
- Forwarding: rd_M=rd_W=7, both writing, rs1_E=7 -> fwd_a_sel=01; reg_wr_en_M=0 -> 10; rs1_E=0 with rd_M=0 -> 00.
- Reset mid-op: rst_n low on the 2nd BUSY cycle -> state RUN, mc_done=0, counters 0, enables 1 after release.
- Counter wrap/clear: CNT_W=4, 16 stall cycles -> stall_cnt=0; perf_clr together with a stall -> counter 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush sequencing for load-use, taken branches
// and multi-cycle EX ops, plus EX operand forwarding selects and perf counters.
module hazard_ctrl #(
    parameter int          MC_LAT = 4,
    parameter logic [1:0]  WB_LD  = 2'b01,
    parameter int          CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_addr_D,
    input  logic [4:0]       rs2_addr_D,
    input  logic [4:0]       rs1_addr_E,
    input  logic [4:0]       rs2_addr_E,
    input  logic [4:0]       rd_addr_E,
    input  logic             reg_wr_en_E,
    input  logic [1:0]       wb_sel_E,
    input  logic [4:0]       rd_addr_M,
    input  logic             reg_wr_en_M,
    input  logic [4:0]       rd_addr_W,
    input  logic             reg_wr_en_W,
    input  logic             br_taken_E,
    input  logic             mc_req_E,
    input  logic             perf_clr,
    output logic             enable_F,
    output logic             enable_D,
    output logic             flush_D,
    output logic             enable_E,
    output logic             flush_E,
    output logic             flush_M,
    output logic             mc_done,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {
        RUN  = 1'b0,
        BUSY = 1'b1
    } state_t;

    // The request cycle itself and the release cycle are not counted down.
    localparam logic [3:0] MC_LOAD = 4'(MC_LAT - 2);

    state_t            state_reg, state_next;
    logic [3:0]        mc_cnt_reg, mc_cnt_next;
    logic [CNT_W-1:0]  stall_cnt_reg, flush_cnt_reg;
    logic              load_use;
    logic              br_honoured;

    logic [1:0][4:0]   rs_e;
    logic [1:0][1:0]   fwd_sel;
    logic [1:0]        ld_hit;
    logic [1:0][4:0]   rs_d;

    assign rs_e[0] = rs1_addr_E;
    assign rs_e[1] = rs2_addr_E;
    assign rs_d[0] = rs1_addr_D;
    assign rs_d[1] = rs2_addr_D;

    // Per-operand forwarding and load-use source matching; x0 never matches.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            logic mem_hit;
            logic wb_hit;

            assign mem_hit = reg_wr_en_M && (rd_addr_M != 5'd0) && (rd_addr_M == rs_e[gi]);
            assign wb_hit  = reg_wr_en_W && (rd_addr_W != 5'd0) && (rd_addr_W == rs_e[gi]);
            assign fwd_sel[gi] = mem_hit ? 2'b01 : (wb_hit ? 2'b10 : 2'b00);

            assign ld_hit[gi] = (rd_addr_E == rs_d[gi]);
        end
    endgenerate

    assign fwd_a_sel = fwd_sel[0];
    assign fwd_b_sel = fwd_sel[1];

    assign load_use = reg_wr_en_E && (wb_sel_E == WB_LD) && (rd_addr_E != 5'd0) && (|ld_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= RUN;
            mc_cnt_reg <= 4'd0;
        end else begin
            state_reg  <= state_next;
            mc_cnt_reg <= mc_cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        mc_cnt_next = mc_cnt_reg;
        enable_F    = 1'b1;
        enable_D    = 1'b1;
        enable_E    = 1'b1;
        flush_D     = 1'b0;
        flush_E     = 1'b0;
        flush_M     = 1'b0;
        mc_done     = 1'b0;
        br_honoured = 1'b0;

        case (state_reg)
            RUN: begin
                if (br_taken_E) begin
                    flush_D     = 1'b1;
                    flush_E     = 1'b1;
                    br_honoured = 1'b1;
                end else if (mc_req_E) begin
                    enable_F    = 1'b0;
                    enable_D    = 1'b0;
                    enable_E    = 1'b0;
                    flush_M     = 1'b1;
                    mc_cnt_next = MC_LOAD;
                    state_next  = BUSY;
                end else if (load_use) begin
                    enable_F = 1'b0;
                    enable_D = 1'b0;
                    flush_E  = 1'b1;
                end
            end
            BUSY: begin
                // Hazard inputs are ignored while the op holds EX.
                if (mc_cnt_reg != 4'd0) begin
                    enable_F    = 1'b0;
                    enable_D    = 1'b0;
                    enable_E    = 1'b0;
                    flush_M     = 1'b1;
                    mc_cnt_next = mc_cnt_reg - 4'd1;
                end else begin
                    mc_done    = 1'b1;
                    state_next = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else if (perf_clr) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (!enable_D) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            end
            if (br_honoured) begin
                flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two instances (MC_LAT=4/CNT_W=4 and
// MC_LAT=2/CNT_W=32) share stimulus and are checked against a behavioural model.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] rs1_addr_D, rs2_addr_D, rs1_addr_E, rs2_addr_E;
    logic [4:0] rd_addr_E, rd_addr_M, rd_addr_W;
    logic       reg_wr_en_E, reg_wr_en_M, reg_wr_en_W;
    logic [1:0] wb_sel_E;
    logic       br_taken_E, mc_req_E, perf_clr;

    logic        en_f0, en_d0, fl_d0, en_e0, fl_e0, fl_m0, done0;
    logic [1:0]  fa0, fb0;
    logic [3:0]  sc0, fc0;
    logic        en_f1, en_d1, fl_d1, en_e1, fl_e1, fl_m1, done1;
    logic [1:0]  fa1, fb1;
    logic [31:0] sc1, fc1;

    logic [10:0] ctl0, ctl1;
    assign ctl0 = {en_f0, en_d0, fl_d0, en_e0, fl_e0, fl_m0, done0, fa0, fb0};
    assign ctl1 = {en_f1, en_d1, fl_d1, en_e1, fl_e1, fl_m1, done1, fa1, fb1};

    hazard_ctrl #(.MC_LAT(4), .WB_LD(2'b01), .CNT_W(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr_D(rs1_addr_D), .rs2_addr_D(rs2_addr_D),
        .rs1_addr_E(rs1_addr_E), .rs2_addr_E(rs2_addr_E),
        .rd_addr_E(rd_addr_E), .reg_wr_en_E(reg_wr_en_E), .wb_sel_E(wb_sel_E),
        .rd_addr_M(rd_addr_M), .reg_wr_en_M(reg_wr_en_M),
        .rd_addr_W(rd_addr_W), .reg_wr_en_W(reg_wr_en_W),
        .br_taken_E(br_taken_E), .mc_req_E(mc_req_E), .perf_clr(perf_clr),
        .enable_F(en_f0), .enable_D(en_d0), .flush_D(fl_d0),
        .enable_E(en_e0), .flush_E(fl_e0), .flush_M(fl_m0), .mc_done(done0),
        .fwd_a_sel(fa0), .fwd_b_sel(fb0), .stall_cnt(sc0), .flush_cnt(fc0)
    );

    hazard_ctrl #(.MC_LAT(2), .WB_LD(2'b01), .CNT_W(32)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .rs1_addr_D(rs1_addr_D), .rs2_addr_D(rs2_addr_D),
        .rs1_addr_E(rs1_addr_E), .rs2_addr_E(rs2_addr_E),
        .rd_addr_E(rd_addr_E), .reg_wr_en_E(reg_wr_en_E), .wb_sel_E(wb_sel_E),
        .rd_addr_M(rd_addr_M), .reg_wr_en_M(reg_wr_en_M),
        .rd_addr_W(rd_addr_W), .reg_wr_en_W(reg_wr_en_W),
        .br_taken_E(br_taken_E), .mc_req_E(mc_req_E), .perf_clr(perf_clr),
        .enable_F(en_f1), .enable_D(en_d1), .flush_D(fl_d1),
        .enable_E(en_e1), .flush_E(fl_e1), .flush_M(fl_m1), .mc_done(done1),
        .fwd_a_sel(fa1), .fwd_b_sel(fb1), .stall_cnt(sc1), .flush_cnt(fc1)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Behavioural model state, one slot per instance.
    bit          m_busy [2];
    int          m_ex   [2];
    logic [31:0] m_sc   [2];
    logic [31:0] m_fc   [2];
    logic [10:0] e_ctl  [2];

    typedef struct packed {
        logic [10:0] c0;
        logic [10:0] c1;
        logic [31:0] s0;
        logic [31:0] s1;
        logic [31:0] f0;
        logic [31:0] f1;
    } exp_t;

    exp_t sb_q[$];

    function automatic int lat_of(int i);
        return (i == 0) ? 4 : 2;
    endfunction

    function automatic logic [1:0] exp_fwd(logic [4:0] rs);
        if (rs == 5'd0) return 2'b00;
        if (reg_wr_en_M && rd_addr_M == rs) return 2'b01;
        if (reg_wr_en_W && rd_addr_W == rs) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 1'b0;
            m_ex[i]   = 0;
            m_sc[i]   = 32'd0;
            m_fc[i]   = 32'd0;
        end
    endtask

    task automatic model_eval();
        bit lu;
        logic ef, ed, fd, ee, fe, fm, dn;
        lu = reg_wr_en_E && (wb_sel_E == 2'b01) && (rd_addr_E != 5'd0) &&
             ((rd_addr_E == rs1_addr_D) || (rd_addr_E == rs2_addr_D));
        for (int i = 0; i < 2; i++) begin
            ef = 1'b1; ed = 1'b1; fd = 1'b0; ee = 1'b1; fe = 1'b0; fm = 1'b0; dn = 1'b0;
            if (m_busy[i]) begin
                if (m_ex[i] == lat_of(i) - 1) dn = 1'b1;
                else begin ef = 1'b0; ed = 1'b0; ee = 1'b0; fm = 1'b1; end
            end else if (br_taken_E) begin
                fd = 1'b1; fe = 1'b1;
            end else if (mc_req_E) begin
                ef = 1'b0; ed = 1'b0; ee = 1'b0; fm = 1'b1;
            end else if (lu) begin
                ef = 1'b0; ed = 1'b0; fe = 1'b1;
            end
            e_ctl[i] = {ef, ed, fd, ee, fe, fm, dn, exp_fwd(rs1_addr_E), exp_fwd(rs2_addr_E)};
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            if (perf_clr) begin
                m_sc[i] = 32'd0;
                m_fc[i] = 32'd0;
            end else begin
                if (!e_ctl[i][9]) m_sc[i] = m_sc[i] + 32'd1;
                if (!m_busy[i] && br_taken_E) m_fc[i] = m_fc[i] + 32'd1;
            end
            if (m_busy[i]) begin
                if (e_ctl[i][4]) m_busy[i] = 1'b0;
                else m_ex[i] = m_ex[i] + 1;
            end else if (!br_taken_E && mc_req_E) begin
                m_busy[i] = 1'b1;
                m_ex[i]   = 1;
            end
        end
    endtask

    // Entered just after a rising edge with inputs already driven.
    task automatic step();
        exp_t e;
        model_eval();
        e.c0 = e_ctl[0];
        e.c1 = e_ctl[1];
        e.s0 = m_sc[0] & 32'hF;
        e.s1 = m_sc[1];
        e.f0 = m_fc[0] & 32'hF;
        e.f1 = m_fc[1];
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        $display("cyc %0d br=%0b mc=%0b clr=%0b ctl0=%03h ctl1=%03h sc0=%0d sc1=%0d fc1=%0d",
                 cyc, br_taken_E, mc_req_E, perf_clr, ctl0, ctl1, sc0, sc1, fc1);
        check("ctl0",   32'(ctl0), 32'(e.c0));
        check("ctl1",   32'(ctl1), 32'(e.c1));
        check("stall0", 32'(sc0),  e.s0);
        check("stall1", sc1,       e.s1);
        check("flush0", 32'(fc0),  e.f0);
        check("flush1", fc1,       e.f1);
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic idle();
        rs1_addr_D = 5'd0; rs2_addr_D = 5'd0; rs1_addr_E = 5'd0; rs2_addr_E = 5'd0;
        rd_addr_E = 5'd0; rd_addr_M = 5'd0; rd_addr_W = 5'd0;
        reg_wr_en_E = 1'b0; reg_wr_en_M = 1'b0; reg_wr_en_W = 1'b0;
        wb_sel_E = 2'b00; br_taken_E = 1'b0; mc_req_E = 1'b0; perf_clr = 1'b0;
    endtask

    task automatic set_load_use(input logic [4:0] rd);
        reg_wr_en_E = 1'b1; wb_sel_E = 2'b01; rd_addr_E = rd; rs1_addr_D = rd;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ctl0"}, 32'(ctl0), 32'h680);
        check({tag, "_ctl1"}, 32'(ctl1), 32'h680);
        check({tag, "_sc0"},  32'(sc0),  32'd0);
        check({tag, "_sc1"},  sc1,       32'd0);
        check({tag, "_fc1"},  fc1,       32'd0);
    endtask

    // Asynchronous reset between edges, released on a falling edge.
    task automatic do_reset();
        idle();
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_reset_state("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(); step();

        // Load-use on rs1, then release
        set_load_use(5'd5); step();
        check("lu_stall", sc1, 32'd1);
        idle(); step();
        check("lu_after", 32'(ctl1), 32'h680);
        // rs2 match, x0 destination, non-load writeback
        reg_wr_en_E = 1'b1; wb_sel_E = 2'b01; rd_addr_E = 5'd6; rs2_addr_D = 5'd6; step();
        rd_addr_E = 5'd0; rs1_addr_D = 5'd0; rs2_addr_D = 5'd0; step();
        wb_sel_E = 2'b00; rd_addr_E = 5'd6; rs2_addr_D = 5'd6; step();
        idle();

        // Branch beats load-use
        perf_clr = 1'b1; step(); perf_clr = 1'b0;
        set_load_use(5'd5); br_taken_E = 1'b1; step();
        idle(); step();
        check("br_flush_cnt", fc1, 32'd1);
        check("br_stall_cnt", sc1, 32'd0);

        // Multi-cycle op held high: back-to-back restarts
        perf_clr = 1'b1; step(); perf_clr = 1'b0;
        mc_req_E = 1'b1; repeat (4) step();
        mc_req_E = 1'b0; step();
        check("mc4_stall", 32'(sc0), 32'd3);
        check("mc2_stall", sc1, 32'd2);
        // Branch and load-use during BUSY are ignored; mc+br together: branch wins
        mc_req_E = 1'b1; step();
        mc_req_E = 1'b0; br_taken_E = 1'b1; set_load_use(5'd4); step();
        idle(); repeat (3) step();
        mc_req_E = 1'b1; br_taken_E = 1'b1; step();
        idle(); step();

        // Forwarding
        rd_addr_M = 5'd7; rd_addr_W = 5'd7; reg_wr_en_M = 1'b1; reg_wr_en_W = 1'b1;
        rs1_addr_E = 5'd7; rs2_addr_E = 5'd7; step();
        reg_wr_en_M = 1'b0; step();
        reg_wr_en_M = 1'b1; rs1_addr_E = 5'd0; rd_addr_M = 5'd0; step();
        rs2_addr_E = 5'd9; rd_addr_W = 5'd9; rd_addr_M = 5'd3; step();
        idle(); step();

        // Reset on the 2nd BUSY cycle
        mc_req_E = 1'b1; step(); step();
        do_reset();
        step(); step();

        // Counter wrap at CNT_W=4 and clear-vs-increment
        perf_clr = 1'b1; step(); perf_clr = 1'b0;
        set_load_use(5'd8); repeat (16) step();
        check("wrap_sc0", 32'(sc0), 32'd0);
        check("wrap_sc1", sc1, 32'd16);
        perf_clr = 1'b1; step();
        check("clr_sc0", 32'(sc0), 32'd0);
        check("clr_sc1", sc1, 32'd0);
        idle(); step();

        // Random traffic
        for (int k = 0; k < 300; k++) begin
            rs1_addr_D  = 5'($urandom_range(0, 3));
            rs2_addr_D  = 5'($urandom_range(0, 3));
            rs1_addr_E  = 5'($urandom_range(0, 3));
            rs2_addr_E  = 5'($urandom_range(0, 3));
            rd_addr_E   = 5'($urandom_range(0, 3));
            rd_addr_M   = 5'($urandom_range(0, 3));
            rd_addr_W   = 5'($urandom_range(0, 3));
            reg_wr_en_E = 1'($urandom_range(0, 1));
            reg_wr_en_M = 1'($urandom_range(0, 1));
            reg_wr_en_W = 1'($urandom_range(0, 1));
            wb_sel_E    = 2'($urandom_range(0, 3));
            br_taken_E  = ($urandom_range(0, 7) == 0);
            mc_req_E    = ($urandom_range(0, 9) == 0);
            perf_clr    = ($urandom_range(0, 31) == 0);
            step();
        end
        idle(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
